// File: rtl/wb_trace_capture.sv
// Trace capture of processor $v0/$v1 changes into a small FIFO, tagged with the fetch PC.
// Optional macro WB_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp per entry (rd_ts).
module wb_trace_capture #(
    parameter int DEPTH = 16,
    parameter int CNTW  = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [31:0]              out_v0,
    input  logic [31:0]              out_v1,
    input  logic [31:0]              out_PC,
    input  logic                     capture_en,
    input  logic                     clr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [1:0]               rd_tag,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNTW-1:0]          drop_cnt
`ifdef WB_TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]              rd_ts
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] pc;
        logic [31:0] value;
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } entry_t;

    logic [31:0]     prev_v0_r;
    logic [31:0]     prev_v1_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW:0]     count_r;
    logic            rd_valid_r;
    logic            overflow_r;
    logic [CNTW-1:0] drop_cnt_r;
    entry_t          head_r;
    entry_t          mem_r [DEPTH];
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0]     ts_r;
`endif

    logic            chg0_s;
    logic            chg1_s;
    logic            pop_s;
    logic [AW:0]     cnt_after_pop_s;
    logic [AW:0]     cnt_nxt_s;
    logic [AW+1:0]   free_s;
    logic [1:0]      n_pend_s;
    logic [1:0]      n_st_s;
    logic [1:0]      n_drop_s;
    logic [AW-1:0]   rd_nxt_s;
    logic [AW-1:0]   wr_ptr1_s;
    logic [AW-1:0]   wr_nxt_s;
    entry_t          entry_a_s;
    entry_t          entry_b_s;
    entry_t          head_nxt_s;
    logic [CNTW+1:0] drop_sum_s;
    logic [CNTW-1:0] drop_nxt_s;

    // Change detection, free space after the same-cycle pop, and next head entry.
    always_comb begin
        chg0_s          = capture_en && (out_v0 != prev_v0_r);
        chg1_s          = capture_en && (out_v1 != prev_v1_r);
        pop_s           = rd_valid_r && rd_ready;
        cnt_after_pop_s = count_r - (AW+1)'(pop_s);
        free_s          = (AW+2)'(DEPTH) - (AW+2)'(cnt_after_pop_s);
        n_pend_s        = {1'b0, chg0_s} + {1'b0, chg1_s};
        if (free_s >= (AW+2)'(n_pend_s)) begin
            n_st_s = n_pend_s;
        end else begin
            n_st_s = free_s[1:0];
        end
        n_drop_s = n_pend_s - n_st_s;

        // Entry A is the v0 change when present, so v0 wins the last free slot.
        entry_a_s    = {$bits(entry_t){1'b0}};
        entry_a_s.pc = out_PC;
`ifdef WB_TRACE_TIMESTAMP_EN
        entry_a_s.ts = ts_r;
`endif
        if (chg0_s) begin
            entry_a_s.tag   = 2'b01;
            entry_a_s.value = out_v0;
        end else begin
            entry_a_s.tag   = 2'b10;
            entry_a_s.value = out_v1;
        end
        entry_b_s       = entry_a_s;
        entry_b_s.tag   = 2'b10;
        entry_b_s.value = out_v1;

        cnt_nxt_s = cnt_after_pop_s + (AW+1)'(n_st_s);
        rd_nxt_s  = rd_ptr_r + AW'(pop_s);
        wr_ptr1_s = wr_ptr_r + AW'(1'b1);
        wr_nxt_s  = wr_ptr_r + AW'(n_st_s);

        if (cnt_nxt_s == {(AW+1){1'b0}}) begin
            head_nxt_s = {$bits(entry_t){1'b0}};
        end else if (cnt_after_pop_s == {(AW+1){1'b0}}) begin
            head_nxt_s = entry_a_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end

        drop_sum_s = (CNTW+2)'(drop_cnt_r) + (CNTW+2)'(n_drop_s);
        if (drop_sum_s > (CNTW+2)'({CNTW{1'b1}})) begin
            drop_nxt_s = {CNTW{1'b1}};
        end else begin
            drop_nxt_s = drop_sum_s[CNTW-1:0];
        end
    end

    // Pointer, occupancy, flag and registered head-of-queue state.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prev_v0_r  <= 32'd0;
            prev_v1_r  <= 32'd0;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            rd_valid_r <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNTW{1'b0}};
            head_r     <= {$bits(entry_t){1'b0}};
        end else begin
            prev_v0_r <= out_v0;
            prev_v1_r <= out_v1;
            if (clr) begin
                rd_ptr_r   <= {AW{1'b0}};
                wr_ptr_r   <= {AW{1'b0}};
                count_r    <= {(AW+1){1'b0}};
                rd_valid_r <= 1'b0;
                overflow_r <= 1'b0;
                drop_cnt_r <= {CNTW{1'b0}};
                head_r     <= {$bits(entry_t){1'b0}};
            end else begin
                rd_ptr_r   <= rd_nxt_s;
                wr_ptr_r   <= wr_nxt_s;
                count_r    <= cnt_nxt_s;
                rd_valid_r <= (cnt_nxt_s != {(AW+1){1'b0}});
                overflow_r <= overflow_r | (n_drop_s != 2'd0);
                drop_cnt_r <= drop_nxt_s;
                head_r     <= head_nxt_s;
            end
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge Clk) begin
        if (Reset && !clr) begin
            if (n_st_s != 2'd0) begin
                mem_r[wr_ptr_r] <= entry_a_s;
            end
            if (n_st_s == 2'd2) begin
                mem_r[wr_ptr1_s] <= entry_b_s;
            end
        end
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    // Free-running cycle stamp, wraps naturally at 16 bits.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ts_r <= 16'd0;
        end else begin
            ts_r <= ts_r + 16'd1;
        end
    end

    assign rd_ts = head_r.ts;
`endif

    assign rd_valid = rd_valid_r;
    assign rd_tag   = head_r.tag;
    assign rd_pc    = head_r.pc;
    assign rd_value = head_r.value;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Bench for wb_trace_capture: queue-based reference model, per-cycle monitor, directed plus random stimulus.
module tb_wb_trace_capture;

    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] out_v0, out_v1, out_PC;
    logic        capture_en, clr, rd_ready;
    logic        rd_valid;
    logic [1:0]  rd_tag;
    logic [31:0] rd_pc, rd_value;
    logic [2:0]  count;
    logic        overflow;
    logic [CNTW-1:0] drop_cnt;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    always #5 Clk = ~Clk;

    wb_trace_capture #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .Clk(Clk), .Reset(Reset),
        .out_v0(out_v0), .out_v1(out_v1), .out_PC(out_PC),
        .capture_en(capture_en), .clr(clr),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_tag(rd_tag), .rd_pc(rd_pc), .rd_value(rd_value),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef WB_TRACE_TIMESTAMP_EN
        , .rd_ts(rd_ts)
`endif
    );

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] pc;
        logic [31:0] value;
        logic [15:0] ts;
    } ent_t;

    ent_t        exp_q[$];
    int          m_ovf = 0;
    int          m_drop = 0;
    int          m_cyc = 0;
    logic [31:0] m_p0 = 32'd0;
    logic [31:0] m_p1 = 32'd0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(input ent_t e);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(e);
        end else begin
            m_ovf = 1;
            if (m_drop < (1 << CNTW) - 1) m_drop++;
        end
    endfunction

    // Reference model: the FIFO is a plain queue, pop first, then pushes with v0 ahead of v1.
    always @(posedge Clk) begin
        ent_t e;
        if (!Reset) begin
            exp_q.delete();
            m_ovf = 0; m_drop = 0; m_p0 = 32'd0; m_p1 = 32'd0; m_cyc = 0;
        end else begin
            if (clr) begin
                exp_q.delete();
                m_ovf = 0; m_drop = 0;
            end else begin
                if (exp_q.size() > 0 && rd_ready) void'(exp_q.pop_front());
                if (capture_en && out_v0 != m_p0) begin
                    e.tag = 2'b01; e.pc = out_PC; e.value = out_v0; e.ts = m_cyc[15:0];
                    m_push(e);
                end
                if (capture_en && out_v1 != m_p1) begin
                    e.tag = 2'b10; e.pc = out_PC; e.value = out_v1; e.ts = m_cyc[15:0];
                    m_push(e);
                end
            end
            m_p0 = out_v0;
            m_p1 = out_v1;
            m_cyc = (m_cyc + 1) % 65536;
        end
    end

    // Monitor: after each edge compare everything the DUT presents with the model.
    always @(posedge Clk) begin
        #1;
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (exp_q.size() > 0) begin
            chk("rd_tag", 32'(rd_tag), 32'(exp_q[0].tag));
            chk("rd_pc", rd_pc, exp_q[0].pc);
            chk("rd_value", rd_value, exp_q[0].value);
`ifdef WB_TRACE_TIMESTAMP_EN
            chk("rd_ts", 32'(rd_ts), 32'(exp_q[0].ts));
`endif
        end else begin
            chk("rd_tag_empty", 32'(rd_tag), 32'd0);
            chk("rd_pc_empty", rd_pc, 32'd0);
            chk("rd_value_empty", rd_value, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0; out_v0 = 32'd0; out_v1 = 32'd0; out_PC = 32'd0;
        capture_en = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        step(2);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(rd_valid), 32'd0);

        Reset = 1'b1; capture_en = 1'b1; step(1);
        chk("first_cycle_no_entry", 32'(count), 32'd0);

        out_v0 = 32'h5; out_PC = 32'h40; step(1);
        chk("basic_valid", 32'(rd_valid), 32'd1);
        chk("basic_tag", 32'(rd_tag), 32'd1);
        chk("basic_pc", rd_pc, 32'h40);
        chk("basic_value", rd_value, 32'h5);
        chk("basic_count", 32'(count), 32'd1);
        rd_ready = 1'b1; step(1);
        chk("basic_drain", 32'(count), 32'd0);

        rd_ready = 1'b0; out_v0 = 32'hA; out_v1 = 32'hB; out_PC = 32'h44; step(1);
        chk("dual_count", 32'(count), 32'd2);
        chk("dual_first_tag", 32'(rd_tag), 32'd1);
        chk("dual_first_value", rd_value, 32'hA);
        rd_ready = 1'b1; step(1);
        chk("dual_second_tag", 32'(rd_tag), 32'd2);
        chk("dual_second_value", rd_value, 32'hB);
        step(1);
        chk("dual_drain", 32'(count), 32'd0);

        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_v0 = 32'h100 + 32'(i); out_PC = 32'h200 + 32'(4 * i); step(1);
        end
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_cnt), 32'd2);
        chk("ovf_head", rd_value, 32'h100);
        for (int i = 0; i < 8; i++) begin
            out_v1 = 32'h300 + 32'(i); step(1);
        end
        chk("drop_saturate", 32'(drop_cnt), 32'd7);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_drops", 32'(drop_cnt), 32'd0);

        for (int i = 0; i < 4; i++) begin
            out_v0 = 32'h400 + 32'(i); step(1);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_head", rd_value, 32'h400);
        rd_ready = 1'b1; out_v0 = 32'h500; step(1);
        chk("full_pushpop_count", 32'(count), 32'd4);
        chk("full_pushpop_noovf", 32'(overflow), 32'd0);
        chk("full_pushpop_head", rd_value, 32'h401);
        step(5);
        chk("full_drain", 32'(count), 32'd0);

        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out_v1 = 32'h600 + 32'(i); step(1);
        end
        chk("pre_reset_count", 32'(count), 32'd3);
        Reset = 1'b0; clr = 1'b1; rd_ready = 1'b1; out_v0 = 32'h777; step(1);
        Reset = 1'b1; clr = 1'b0; rd_ready = 1'b0; capture_en = 1'b0;
        chk("midburst_reset_count", 32'(count), 32'd0);
        chk("midburst_reset_valid", 32'(rd_valid), 32'd0);
        out_v1 = 32'h999; step(1);
        chk("capture_off", 32'(count), 32'd0);
        capture_en = 1'b1; step(1);
        chk("capture_on_no_change", 32'(count), 32'd0);

`ifdef WB_TRACE_TIMESTAMP_EN
        out_v0 = 32'd0; out_v1 = 32'd0; Reset = 1'b0; step(1);
        Reset = 1'b1; step(10);
        out_v0 = 32'h1; step(3);
        out_v0 = 32'h2; step(1);
        chk("ts_first", 32'(rd_ts), 32'd10);
        rd_ready = 1'b1; step(1);
        chk("ts_second", 32'(rd_ts), 32'd13);
        step(1);
        rd_ready = 1'b0;
`endif

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) out_v0 = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) out_v1 = $urandom_range(0, 7);
            out_PC     = $urandom;
            capture_en = ($urandom_range(0, 9) != 0);
            rd_ready   = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            clr        = ($urandom_range(0, 99) == 0);
            Reset      = ($urandom_range(0, 199) != 0);
            step(1);
        end
        Reset = 1'b1; clr = 1'b0; step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_capture.md
WB_TRACE_CAPTURE -- requirements
Module: wb_trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, range 4..256.
REQ-002 Parameter CNTW, default 8, width of drop counter.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 out_v0  input  32  processor $v0 mirror.
REQ-006 out_v1  input  32  processor $v1 mirror.
REQ-007 out_PC  input  32  processor fetch PC.
REQ-008 capture_en  input  1  enables change detection.
REQ-009 clr  input  1  synchronous FIFO/flag clear pulse.
REQ-010 rd_valid  output  1  head entry available.
REQ-011 rd_ready  input  1  consumer accepts head entry.
REQ-012 rd_tag  output  2  01 = v0 entry, 10 = v1 entry.
REQ-013 rd_pc  output  32  out_PC sampled at the detected change.
REQ-014 rd_value  output  32  new register value.
REQ-015 count  output  log2(DEPTH)+1  occupancy.
REQ-016 overflow  output  1  sticky; set when any entry is dropped.
REQ-017 drop_cnt  output  CNTW  saturating count of dropped entries.

Function
REQ-018 The block SHALL hold prev_v0/prev_v1 registers; a change is out_vX != prev_vX while capture_en=1; prev_vX SHALL update every cycle regardless of capture_en.
REQ-019 A detected change SHALL push {tag, out_PC, out_vX} in the same edge; the entry SHALL be visible at rd_valid one cycle after the change cycle.
REQ-020 Simultaneous v0 and v1 changes SHALL push two entries in one cycle, v0 ahead of v1.
REQ-021 A pop SHALL occur on the edge where rd_valid=1 and rd_ready=1; rd_tag/rd_pc/rd_value SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-022 Free space SHALL be computed after the same-cycle pop: push and pop on a full FIFO SHALL succeed with no drop.
REQ-023 If free space < pending pushes, v0 is kept first; each unstored entry SHALL set overflow and increment drop_cnt, saturating at all-ones.
REQ-024 rd_valid SHALL equal (count != 0); when empty, rd_tag/rd_pc/rd_value SHALL be 0.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-026 clr=1 SHALL empty the FIFO and clear overflow and drop_cnt; pushes and pops in that cycle are discarded; prev_vX still updates.

Reset
REQ-027 Reset=0 at an edge SHALL set count, pointers, overflow, drop_cnt, prev_v0 and prev_v1 to 0 and drive rd_valid=0; the prior FIFO contents are discarded.
REQ-028 Reset asserted mid-burst SHALL take priority over clr, push and pop.
REQ-029 The first cycle after reset with out_vX=0 SHALL not produce an entry.

Configuration
REQ-030 Macro WB_TRACE_TIMESTAMP_EN: when defined, the block SHALL add a free-running 16-bit cycle counter, reset to 0 and wrapping at 65535, and output rd_ts (16 bits, the counter value at push) stored per entry; when undefined, the block SHALL have no counter and no rd_ts port, and its behaviour is otherwise identical.

Verification
REQ-031 Reset, then out_v0 0->0x5 with out_PC=0x40, capture_en=1, rd_ready=0 -> next cycle rd_valid=1, rd_tag=01, rd_pc=0x40, rd_value=0x5, count=1.
REQ-032 v0->0xA and v1->0xB in the same cycle -> count=2; first pop returns tag 01 / 0xA, second pop returns tag 10 / 0xB.
REQ-033 DEPTH=4, rd_ready=0, 6 single changes -> count=4, overflow=1, drop_cnt=2; a later clr -> count=0, overflow=0, drop_cnt=0.
REQ-034 FIFO full with rd_ready=1 and one change -> no drop, count stays 4, and the popped entry is the oldest one.
REQ-035 Reset=0 asserted while count=3 -> next cycle count=0 and rd_valid=0; with capture_en=0 a change of v1 -> no entry, and a later capture_en=1 without a further change -> no entry.
REQ-036 With WB_TRACE_TIMESTAMP_EN defined, changes at cycles 10 and 13 after reset -> rd_ts values 10 and 13.
